// File: rtl/ct_l2c_data_sram_ctrl_pkg.sv
// ct_l2c_data_sram_ctrl_pkg: shared widths, FSM state encoding and SRAM idle pin values for the L2 data SRAM controller
package ct_l2c_data_sram_ctrl_pkg;
  localparam int L2C_DATA_ADDR_WIDTH = 15;
  localparam int L2C_DATA_WIDTH = 128;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} l2c_state_e;
  localparam logic SRAM_CEN_IDLE = 1'b1;
  localparam logic SRAM_GWEN_IDLE = 1'b1;
  localparam logic [L2C_DATA_WIDTH-1:0] SRAM_WEN_IDLE = '1;
endpackage

// File: rtl/ct_l2c_data_sram_ctrl_rr_arb.sv
// ct_l2c_sram_rr_arb: 2-way round-robin arbiter; ports cpuclk/cpurst_b, i_vld[1:0], i_en -> one-hot o_grant[1:0], o_ptr
module ct_l2c_sram_rr_arb (
  input  logic       cpuclk,
  input  logic       cpurst_b,
  input  logic [1:0] i_vld,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_ptr
);
  logic r_ptr;
  logic w_both;
  assign w_both = i_en & (&i_vld);
  assign o_grant = !i_en ? 2'b00 : w_both ? (r_ptr ? 2'b10 : 2'b01) : i_vld;
  assign o_ptr = r_ptr;
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_ptr <= 1'b0;
    else if (w_both) r_ptr <= ~r_ptr;
  end
endmodule

// File: rtl/ct_l2c_data_sram_ctrl.sv
// ct_l2c_data_sram_ctrl: arbitrates two requesters onto one registered single-port SRAM, 2-cycle read return, optional zero-init sweep (L2C_SRAM_INIT_EN)
// Ports: cpuclk/cpurst_b; p0_*/p1_* request (vld, wr, addr, data, active-low wen) with rdy; rd_data_vld/src/data;
// init_done; sram_cen/gwen/a/d/wen pin flops; sram_q from the SRAM.
module ct_l2c_data_sram_ctrl
  import ct_l2c_data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = L2C_DATA_ADDR_WIDTH,
  parameter int DATA_WIDTH = L2C_DATA_WIDTH
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic                  p0_req_vld,
  input  logic                  p0_req_wr,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_data,
  input  logic [DATA_WIDTH-1:0] p0_req_wen,
  output logic                  p0_req_rdy,
  input  logic                  p1_req_vld,
  input  logic                  p1_req_wr,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_data,
  input  logic [DATA_WIDTH-1:0] p1_req_wen,
  output logic                  p1_req_rdy,
  output logic                  rd_data_vld,
  output logic                  rd_data_src,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  logic                  w_init;
  logic                  w_run_en;
  logic [ADDR_WIDTH-1:0] w_init_a;
`ifdef L2C_SRAM_INIT_EN
  l2c_state_e            r_state;
  l2c_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= ST_INIT;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = (r_state == ST_INIT && &r_cnt) ? ST_RUN : r_state;
  end
  // init_done trails the state change by one cycle so the last sweep write owns the pins alone
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
      r_init_done <= r_init_done | (r_state == ST_RUN);
    end
  end
  assign w_init    = (r_state == ST_INIT);
  assign w_init_a  = r_cnt;
  assign w_run_en  = r_init_done;
  assign init_done = r_init_done;
`else
  assign w_init    = 1'b0;
  assign w_init_a  = '0;
  assign w_run_en  = 1'b1;
  assign init_done = 1'b1;
`endif
  logic [1:0]            w_gnt;
  logic                  w_gv;
  logic                  w_sel;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_wen;
  ct_l2c_sram_rr_arb u_arb (
    .cpuclk  (cpuclk),
    .cpurst_b(cpurst_b),
    .i_vld   ({p1_req_vld, p0_req_vld}),
    .i_en    (w_run_en & cpurst_b),
    .o_grant (w_gnt),
    .o_ptr   ()
  );
  assign p0_req_rdy = w_gnt[0];
  assign p1_req_rdy = w_gnt[1];
  assign w_gv  = |w_gnt;
  assign w_sel = w_gnt[1];
  assign w_wr  = w_sel ? p1_req_wr : p0_req_wr;
  assign w_a   = w_sel ? p1_req_addr : p0_req_addr;
  assign w_d   = w_sel ? p1_req_data : p0_req_data;
  assign w_wen = w_sel ? p1_req_wen : p0_req_wen;
  logic                  r_cen;
  logic                  r_gwen;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_wen;
  logic                  w_cen_nxt;
  logic                  w_gwen_nxt;
  logic [ADDR_WIDTH-1:0] w_a_nxt;
  logic [DATA_WIDTH-1:0] w_d_nxt;
  logic [DATA_WIDTH-1:0] w_wen_nxt;
  always_comb begin
    w_cen_nxt  = (w_init | w_gv) ? 1'b0 : SRAM_CEN_IDLE;
    w_gwen_nxt = w_init ? 1'b0 : w_gv ? ~w_wr : SRAM_GWEN_IDLE;
    w_wen_nxt  = w_init ? '0 : (w_gv & w_wr) ? w_wen : SRAM_WEN_IDLE;
    w_a_nxt    = w_init ? w_init_a : w_gv ? w_a : r_a;
    w_d_nxt    = w_init ? '0 : (w_gv & w_wr) ? w_d : r_d;
  end
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cen  <= SRAM_CEN_IDLE;
      r_gwen <= SRAM_GWEN_IDLE;
      r_wen  <= SRAM_WEN_IDLE;
      r_a    <= '0;
      r_d    <= '0;
    end else begin
      r_cen  <= w_cen_nxt;
      r_gwen <= w_gwen_nxt;
      r_wen  <= w_wen_nxt;
      r_a    <= w_a_nxt;
      r_d    <= w_d_nxt;
    end
  end
  assign sram_cen  = r_cen;
  assign sram_gwen = r_gwen;
  assign sram_wen  = r_wen;
  assign sram_a    = r_a;
  assign sram_d    = r_d;
  // stage 1 covers the pin flops, stage 2 the SRAM's own output register
  logic r_v1, r_s1, r_v2, r_s2;
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_v1 <= 1'b0;
      r_s1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_v1 <= w_gv & ~w_wr;
      r_s1 <= w_sel;
      r_v2 <= r_v1;
      r_s2 <= r_s1;
    end
  end
  assign rd_data_vld = r_v2;
  assign rd_data_src = r_s2;
  assign rd_data     = sram_q;
endmodule

// File: doc/ct_l2c_data_sram_ctrl.md
# ct_l2c_data_sram_ctrl

Access controller for one 32768x128 L2 data SRAM bank, placed between the L2 pipeline and the single-port SRAM wrapper. Arbitrates two requesters, the tag/data pipeline on port 0 and the refill/writeback engine on port 1, onto the one SRAM port with round-robin fairness. Registers all SRAM pins and returns read data with a fixed latency. Optionally sequences a post-reset zero-initialisation sweep of the whole array.

## Interface
Parameters:
- ADDR_WIDTH, 15, SRAM word address width (32768 entries).
- DATA_WIDTH, 128, data and bit-write-mask width.

Ports:
- cpuclk  in  1  the one clock.
- cpurst_b  in  1  asynchronous, active-low reset.
- pN_req_vld  in  1  port N (N=0,1) request valid.
- pN_req_wr  in  1  1=write, 0=read.
- pN_req_addr  in  ADDR_WIDTH  word address.
- pN_req_data  in  DATA_WIDTH  write data.
- pN_req_wen  in  DATA_WIDTH  per-bit write enable, active low. Ignored for reads.
- pN_req_rdy  out  1  request accepted this cycle.
- rd_data_vld  out  1  read data valid.
- rd_data_src  out  1  port that issued the returning read.
- rd_data  out  DATA_WIDTH  read data, equal to sram_q.
- init_done  out  1  array usable. Sticky until reset.
- sram_cen, sram_gwen  out  1  chip enable and global write enable, both active low.
- sram_a  out  ADDR_WIDTH; sram_d, sram_wen  out  DATA_WIDTH  SRAM pins.
- sram_q  in  DATA_WIDTH  SRAM output, valid the cycle after an enabled read.

## Operation
- States: INIT, then RUN. Reset enters INIT.
- INIT:
  - A 15-bit counter starts at 0. Each cycle issues a write of address=counter with sram_d=0, sram_wen all 0 and sram_gwen=0.
  - After address 32767 is issued, init_done=1 and the state moves to RUN.
  - Both pN_req_rdy stay 0 throughout INIT.
- RUN arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the port selected by the round-robin pointer. The pointer then moves to the other port.
  - The pointer resets to port 0 and updates only on a contended grant.
  - At most one grant per cycle. pN_req_rdy is high only for the granted port in the grant cycle.
- Request capture: a granted request is registered into the SRAM pin flops.
  - Read: cen=0, gwen=1, wen all 1.
  - Write: cen=0, gwen=0, wen=pN_req_wen, d=pN_req_data.
  - Idle cycle: cen=1, gwen=1, wen all 1. sram_a and sram_d hold their previous values.
- Read return:
  - rd_data_vld and rd_data_src come from a 2-stage valid/src pipeline.
  - rd_data is sram_q passed through combinationally.
  - Writes produce no response.
- A read to an address written in the immediately preceding grant returns the new data, because the SRAM is sequential.
- Requesters must hold vld, addr, data and wen stable until rdy. Dropping vld before rdy is legal and simply withdraws the request.

## Timing
- Grant at cycle T → SRAM pins driven at T+1 → sram_q and rd_data_vld at T+2. Read latency is fixed at 2.
- Sustained throughput is 1 access per cycle. With both ports continuously valid they alternate 0,1,0,1.
- Reset values:
  - sram_cen=1, sram_gwen=1, sram_wen all 1, sram_a=0, sram_d=0.
  - pN_req_rdy=0, rd_data_vld=0, rd_data_src=0, init_done=0 (see Configuration), pointer=0, counter=0.
- INIT occupies exactly 32768 cycles of cen=0, starting the first cycle after reset release. init_done rises the cycle after the last init write is on the pins. Port 0 may be granted in that same cycle.
- Reset asserted mid-INIT: all state clears asynchronously and the sweep restarts at address 0 on release.
- Reset asserted mid-read: in-flight responses are dropped and rd_data_vld=0.

## Configuration
- L2C_SRAM_INIT_EN defined: INIT sweep present, as described above.
- Undefined: no counter and no INIT state. The block resets into RUN, init_done resets to 1, and requests may be granted from the first cycle after reset release. Array contents are undefined until written.

## Structure
- Shared package holds:
  - L2C_DATA_ADDR_WIDTH=15 and L2C_DATA_WIDTH=128.
  - The state encoding (INIT=1'b0, RUN=1'b1).
  - The SRAM idle pin constants (cen=1, gwen=1, wen all 1).
- Sub-module ct_l2c_sram_rr_arb: 2-way round-robin arbiter.
  - Inputs: vld[1:0], enable.
  - Outputs: one-hot grant[1:0] and the pointer state.

## Test plan
- Reset release with L2C_SRAM_INIT_EN → 32768 consecutive zero writes on addresses 0..32767, rdy=0 throughout, init_done=1 right after the last write.
- p0 write addr 0x1234, data 0xA5..A5, wen all 0; then p0 read 0x1234 → rd_data_vld=1 two cycles after the read grant, rd_data=0xA5..A5, rd_data_src=0.
- p0 and p1 both continuously valid reads for 6 cycles → grants p0,p1,p0,p1,p0,p1; responses return in the same order at +2 cycles each.
- Partial write to 0x7FFF with data all 1 and wen=0xFFFF..FFFF0000 over zeroed contents → read returns 0x0000..0000FFFF.
- cpurst_b asserted at INIT count 1000 and released → counter restarts at 0 and the sweep again takes a full 32768 cycles.
- Without L2C_SRAM_INIT_EN → init_done=1 out of reset, and a p1 read granted in the first cycle after reset release returns at +2 cycles.
